// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package rf_pkg;

   localparam int unsigned DEF_XLEN  = 32'd32;
   localparam int unsigned DEF_NREGS = 32'd32;

   // Smallest w with 2**w >= n; used to size register addresses.
   function automatic int unsigned rf_clog2(input int unsigned n);
      int unsigned w;
      w = 32'd0;
      for (int unsigned k = 32'd0; k < 32'd31; k++) begin
         w = ((32'd1 << k) < n) ? (k + 32'd1) : w;
      end
      return w;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy flag per architectural register.
// Issue sets a flag, any write-back to that register clears it; a set in
// the same cycle as a clear wins because it represents a newer producer.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned NREGS  = DEF_NREGS,
   parameter int unsigned NUM_RD = 32'd2,
   parameter int unsigned NUM_WR = 32'd1,
   parameter int unsigned AW     = rf_clog2(DEF_NREGS)
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sb_set,
   input  logic [AW-1:0]         sb_set_addr,
   input  logic [NUM_WR-1:0]     wr_en,
   input  logic [NUM_WR*AW-1:0]  wr_addr,
   input  logic [NUM_RD*AW-1:0]  rd_addr,
   output logic [NUM_RD-1:0]     rd_busy
);

   localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

   logic [NREGS-1:0] busy_r;
   logic [NREGS-1:0] busy_nxt_s;
   logic [NREGS-1:0] set_vec_s;
   logic [NREGS-1:0] clr_vec_s;

   // Decode set/clear requests and form the next busy vector (set beats clear).
   always_comb begin
      set_vec_s = sb_set ? (ONE_HOT0 << sb_set_addr) : {NREGS{1'b0}};
      clr_vec_s = {NREGS{1'b0}};
      for (int j = 0; j < NUM_WR; j++) begin
         clr_vec_s = clr_vec_s |
                     (wr_en[j] ? (ONE_HOT0 << wr_addr[j*AW +: AW]) : {NREGS{1'b0}});
      end
      busy_nxt_s    = (busy_r & ~clr_vec_s) | set_vec_s;
      busy_nxt_s[0] = 1'b0;
   end

   // Busy flag storage, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= {NREGS{1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   // Per-read-port busy lookup; reflects state after the last edge only.
   always_comb begin
      rd_busy = {NUM_RD{1'b0}};
      for (int i = 0; i < NUM_RD; i++) begin
         rd_busy[i] = busy_r[rd_addr[i*AW +: AW]];
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with hardwired-zero r0, optional
// write-to-read bypass, optional registered read data and a scoreboard.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int unsigned XLEN     = DEF_XLEN,
   parameter int unsigned NREGS    = DEF_NREGS,
   parameter int unsigned NUM_RD   = 32'd2,
   parameter int unsigned NUM_WR   = 32'd1,
   parameter int unsigned BYPASS   = 32'd1,
   parameter int unsigned READ_REG = 32'd0,
   localparam int unsigned AW      = rf_clog2(NREGS)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*XLEN-1:0]  rd_data,
   output logic [NUM_RD-1:0]       rd_busy,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*AW-1:0]    wr_addr,
   input  logic [NUM_WR*XLEN-1:0]  wr_data,
   input  logic                    sb_set,
   input  logic [AW-1:0]           sb_set_addr
);

   logic [XLEN-1:0]        regs_r [NREGS];
   logic [NUM_RD*XLEN-1:0] rd_comb_s;

   // Register storage; ports are applied in index order so the highest port wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREGS; k++) begin
            regs_r[k] <= {XLEN{1'b0}};
         end
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != {AW{1'b0}})) begin
               regs_r[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Read muxes with optional forwarding of same-cycle write data (highest port wins).
   always_comb begin
      logic [XLEN-1:0] val_v;
      logic            hit_v;
      rd_comb_s = {(NUM_RD*XLEN){1'b0}};
      for (int i = 0; i < NUM_RD; i++) begin
         val_v = regs_r[rd_addr[i*AW +: AW]];
         for (int j = 0; j < NUM_WR; j++) begin
            hit_v = (BYPASS != 32'd0) && wr_en[j] &&
                    (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]) &&
                    (rd_addr[i*AW +: AW] != {AW{1'b0}});
            val_v = hit_v ? wr_data[j*XLEN +: XLEN] : val_v;
         end
         rd_comb_s[i*XLEN +: XLEN] = val_v;
      end
   end

   generate
      if (READ_REG != 32'd0) begin : g_rd_reg
         logic [NUM_RD*XLEN-1:0] rd_data_r;

         // Output stage: sample the (bypassed) read value, cleared asynchronously.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_data_r <= {(NUM_RD*XLEN){1'b0}};
            end else begin
               rd_data_r <= rd_comb_s;
            end
         end

         assign rd_data = rd_data_r;
      end else begin : g_rd_comb
         assign rd_data = rd_comb_s;
      end
   endgenerate

   rf_scoreboard #(
      .NREGS  (NREGS),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR),
      .AW     (AW)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .sb_set      (sb_set),
      .sb_set_addr (sb_set_addr),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .rd_addr     (rd_addr),
      .rd_busy     (rd_busy)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: three configurations share one stimulus stream.
//   dut_a: 2 write ports, bypass, combinational read
//   dut_b: 1 write port (sees port 0 only), no bypass, combinational read
//   dut_c: 2 write ports, bypass, registered read
module tb_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        sb_set;
   logic [4:0]  sb_set_addr;
   logic [63:0] rd_data_a, rd_data_b, rd_data_c;
   logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_c;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: architectural contents and pending flags.
   logic [31:0] m_a [32];
   logic [31:0] m_b [32];
   bit          bz_a [32];
   bit          bz_b [32];
   logic [31:0] exp_c [2];

   always #5 clk = ~clk;

   reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .READ_REG(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_set_addr(sb_set_addr));

   reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0), .READ_REG(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en[0:0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[31:0]), .sb_set(sb_set),
      .sb_set_addr(sb_set_addr));

   reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .READ_REG(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_set_addr(sb_set_addr));

   // Expected read for the bypassing configuration: newest same-cycle write to a nonzero reg, else stored.
   function automatic logic [31:0] exp_rd_a(int p);
      int a;
      logic [31:0] v;
      a = int'(rd_addr[p*5 +: 5]);
      v = m_a[a];
      for (int j = 0; j < 2; j++) begin
         if (wr_en[j] && int'(wr_addr[j*5 +: 5]) == a && a != 0) v = wr_data[j*32 +: 32];
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_rd_b(int p);
      return m_b[int'(rd_addr[p*5 +: 5])];
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 32; k++) begin
         m_a[k] = 32'h0; m_b[k] = 32'h0; bz_a[k] = 1'b0; bz_b[k] = 1'b0;
      end
      exp_c[0] = 32'h0; exp_c[1] = 32'h0;
   endtask

   // Advance one clock edge, applying the architectural effect of the current inputs.
   task automatic tick();
      logic [31:0] samp [2];
      int a;
      samp[0] = 32'h0; samp[1] = 32'h0;
      if (rst_n) begin
         samp[0] = exp_rd_a(0);
         samp[1] = exp_rd_a(1);
         for (int j = 0; j < 2; j++) begin
            if (wr_en[j]) begin
               a = int'(wr_addr[j*5 +: 5]);
               if (a != 0) m_a[a] = wr_data[j*32 +: 32];
               bz_a[a] = 1'b0;
               if (j == 0) begin
                  if (a != 0) m_b[a] = wr_data[31:0];
                  bz_b[a] = 1'b0;
               end
            end
         end
         if (sb_set && sb_set_addr != 5'd0) begin
            bz_a[int'(sb_set_addr)] = 1'b1;
            bz_b[int'(sb_set_addr)] = 1'b1;
         end
      end
      @(posedge clk);
      if (rst_n) begin
         exp_c[0] = samp[0];
         exp_c[1] = samp[1];
      end
   endtask

   task automatic idle_inputs();
      wr_en = 2'b00; sb_set = 1'b0; sb_set_addr = 5'd0; wr_addr = 10'd0; wr_data = 64'h0;
   endtask

   task automatic test_reset();
      // Build up some non-zero state first.
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         wr_en = 2'($urandom_range(0, 3));
         wr_addr = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
         wr_data = {32'($urandom), 32'($urandom)};
         sb_set = 1'b1; sb_set_addr = 5'($urandom_range(1, 31));
         tick();
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      wr_en = 2'b11; wr_addr = {5'd6, 5'd5}; wr_data = 64'hCAFEF00D_12345678;
      sb_set = 1'b1; sb_set_addr = 5'd5; rd_addr = {5'd9, 5'd8};
      #1;
      model_clear();
      n_vec++;
      if (rd_data_c !== 64'h0) begin
         n_err++; $display("FAIL reset_rdreg_immediate: got %h expected %h", rd_data_c, 64'h0);
      end
      n_vec++;
      if ({rd_busy_a, rd_busy_b, rd_busy_c} !== 6'b0) begin
         n_err++; $display("FAIL reset_busy: got %b expected 000000", {rd_busy_a, rd_busy_b, rd_busy_c});
      end
      tick();
      tick();
      @(negedge clk);
      n_vec++;
      if (rd_data_c !== 64'h0) begin
         n_err++; $display("FAIL reset_hold_rdreg: got %h expected 0", rd_data_c);
      end
      rst_n = 1'b1;
      idle_inputs();
      // Sweep every address on both ports.
      for (int a = 0; a < 32; a++) begin
         if (a != 0) @(negedge clk);
         rd_addr = {5'(31 - a), 5'(a)};
         #1;
         for (int p = 0; p < 2; p++) begin
            n_vec++;
            if (rd_data_a[p*32 +: 32] !== 32'h0 || rd_data_b[p*32 +: 32] !== 32'h0) begin
               n_err++;
               $display("FAIL reset_sweep addr=%0d port=%0d: got a=%h b=%h expected 0",
                        rd_addr[p*5 +: 5], p, rd_data_a[p*32 +: 32], rd_data_b[p*32 +: 32]);
            end
         end
         n_vec++;
         if ({rd_busy_a, rd_busy_b} !== 4'b0) begin
            n_err++; $display("FAIL reset_sweep_busy addr=%0d: got %b expected 0000", a, {rd_busy_a, rd_busy_b});
         end
         tick();
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
      tick();
      @(negedge clk);
      idle_inputs();
      rd_addr = {5'd0, 5'd5};
      #1;
      n_vec++;
      if (rd_data_a[31:0] !== 32'hDEADBEEF || rd_data_b[31:0] !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL write_read_r5: got a=%h b=%h expected deadbeef", rd_data_a[31:0], rd_data_b[31:0]);
      end
      wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h00001234};
      tick();
      @(negedge clk);
      idle_inputs();
      rd_addr = {5'd0, 5'd0};
      #1;
      n_vec++;
      if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
         n_err++; $display("FAIL r0_hardwired: got a=%h b=%h expected 0", rd_data_a, rd_data_b);
      end
      tick();
   endtask

   task automatic test_bypass();
      @(negedge clk);
      wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h11111111};
      tick();
      @(negedge clk);
      wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hA5A5A5A5};
      rd_addr = {5'd7, 5'd0};
      #1;
      n_vec++;
      if (rd_data_a[63:32] !== 32'hA5A5A5A5) begin
         n_err++; $display("FAIL bypass_on: got %h expected a5a5a5a5", rd_data_a[63:32]);
      end
      n_vec++;
      if (rd_data_b[63:32] !== 32'h11111111) begin
         n_err++; $display("FAIL bypass_off_old: got %h expected 11111111", rd_data_b[63:32]);
      end
      tick();
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (rd_data_c[63:32] !== 32'hA5A5A5A5) begin
         n_err++; $display("FAIL bypass_sampled_rdreg: got %h expected a5a5a5a5", rd_data_c[63:32]);
      end
      n_vec++;
      if (rd_data_b[63:32] !== 32'hA5A5A5A5) begin
         n_err++; $display("FAIL bypass_off_after_edge: got %h expected a5a5a5a5", rd_data_b[63:32]);
      end
      tick();
   endtask

   task automatic test_conflict();
      @(negedge clk);
      wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'd2, 32'd1};
      tick();
      @(negedge clk);
      wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'd6, 32'd5};
      rd_addr = {5'd3, 5'd3};
      #1;
      n_vec++;
      if (rd_data_a[31:0] !== 32'd6) begin
         n_err++; $display("FAIL conflict_bypass: got %h expected 6", rd_data_a[31:0]);
      end
      n_vec++;
      if (rd_data_b[31:0] !== 32'd1) begin
         n_err++; $display("FAIL conflict_single_port: got %h expected 1", rd_data_b[31:0]);
      end
      @(negedge clk);
      // Re-enter: the first pair committed at the last edge only if tick ran; rewind by applying pair again.
      idle_inputs();
      wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'd2, 32'd1};
      tick();
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (rd_data_a[31:0] !== 32'd2) begin
         n_err++; $display("FAIL conflict_high_port_wins: got %h expected 2", rd_data_a[31:0]);
      end
      tick();
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      idle_inputs();
      sb_set = 1'b1; sb_set_addr = 5'd9; rd_addr = {5'd0, 5'd9};
      #1;
      n_vec++;
      if (rd_busy_a[0] !== 1'b0) begin
         n_err++; $display("FAIL sb_not_bypassed: got %b expected 0", rd_busy_a[0]);
      end
      tick();
      @(negedge clk);
      sb_set = 1'b0;
      #1;
      n_vec++;
      if ({rd_busy_a[0], rd_busy_b[0], rd_busy_c[0]} !== 3'b111) begin
         n_err++; $display("FAIL sb_set_r9: got %b expected 111", {rd_busy_a[0], rd_busy_b[0], rd_busy_c[0]});
      end
      wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
      tick();
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if ({rd_busy_a[0], rd_busy_b[0]} !== 2'b00) begin
         n_err++; $display("FAIL sb_clear_r9: got %b expected 00", {rd_busy_a[0], rd_busy_b[0]});
      end
      sb_set = 1'b1; sb_set_addr = 5'd9;
      wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h77, 32'h0};
      tick();
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (rd_busy_a[0] !== 1'b1) begin
         n_err++; $display("FAIL sb_set_beats_clear: got %b expected 1", rd_busy_a[0]);
      end
      sb_set = 1'b1; sb_set_addr = 5'd0; rd_addr = {5'd0, 5'd0};
      tick();
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (rd_busy_a !== 2'b00) begin
         n_err++; $display("FAIL sb_r0_never_busy: got %b expected 00", rd_busy_a);
      end
      tick();
   endtask

   task automatic test_read_reg();
      @(negedge clk);
      wr_en = 2'b11; wr_addr = {5'd4, 5'd2}; wr_data = {32'h44444444, 32'h22222222};
      tick();
      @(negedge clk);
      idle_inputs();
      rd_addr = {5'd0, 5'd2};
      tick();
      @(negedge clk);
      rd_addr = {5'd0, 5'd4};
      #1;
      n_vec++;
      if (rd_data_c[31:0] !== 32'h22222222) begin
         n_err++; $display("FAIL rdreg_latency_old: got %h expected 22222222", rd_data_c[31:0]);
      end
      tick();
      @(negedge clk);
      #1;
      n_vec++;
      if (rd_data_c[31:0] !== 32'h44444444) begin
         n_err++; $display("FAIL rdreg_latency_new: got %h expected 44444444", rd_data_c[31:0]);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      model_clear();
      n_vec++;
      if (rd_data_c !== 64'h0) begin
         n_err++; $display("FAIL rdreg_async_reset: got %h expected 0", rd_data_c);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random(int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         wr_en = 2'($urandom_range(0, 3));
         wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wr_data = {32'($urandom), 32'($urandom)};
         sb_set = 1'($urandom_range(0, 1));
         sb_set_addr = 5'($urandom_range(0, 7));
         rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         #1;
         for (int p = 0; p < 2; p++) begin
            n_vec++;
            if (rd_data_a[p*32 +: 32] !== exp_rd_a(p) || rd_data_b[p*32 +: 32] !== exp_rd_b(p) ||
                rd_data_c[p*32 +: 32] !== exp_c[p]) begin
               n_err++;
               $display("FAIL random_rd cyc=%0d port=%0d: got a=%h b=%h c=%h expected a=%h b=%h c=%h",
                        k, p, rd_data_a[p*32 +: 32], rd_data_b[p*32 +: 32], rd_data_c[p*32 +: 32],
                        exp_rd_a(p), exp_rd_b(p), exp_c[p]);
            end
            n_vec++;
            if (rd_busy_a[p] !== bz_a[int'(rd_addr[p*5 +: 5])] || rd_busy_b[p] !== bz_b[int'(rd_addr[p*5 +: 5])] ||
                rd_busy_c[p] !== bz_a[int'(rd_addr[p*5 +: 5])]) begin
               n_err++;
               $display("FAIL random_busy cyc=%0d port=%0d: got a=%b b=%b c=%b expected a=%b b=%b",
                        k, p, rd_busy_a[p], rd_busy_b[p], rd_busy_c[p],
                        bz_a[int'(rd_addr[p*5 +: 5])], bz_b[int'(rd_addr[p*5 +: 5])]);
            end
         end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rd_addr = 10'd0;
      idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_write_read();
      test_bypass();
      test_conflict();
      test_scoreboard();
      test_read_reg();
      test_random(400);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
